// File: rtl/vc_rr_stream_mux.sv
// ============================================================================
// vc_rr_stream_mux
//
// Round-robin N-input stream multiplexer with val/rdy handshakes.
// A round-robin arbiter picks one valid input channel each cycle. The
// winning message is registered together with the id of its source channel.
// There is one cycle of latency from input acceptance to out_msg.
//
// Build option:
//   VC_RR_STREAM_MUX_SKID_EN  undefined -> 1-entry pipe register. in_rdy
//                                          depends combinationally on out_rdy.
//                             defined   -> 2-entry skid FIFO. in_rdy depends
//                                          only on registered state.
//
// Parameters:
//   p_nbits     message width in bits
//   p_ninputs   number of input channels (>= 1, any value)
//   c_sel_nbits width of channel ids, max(1, clog2(p_ninputs))
//
// Ports:
//   clk      clock; all state updates on its rising edge
//   reset    synchronous, active-high reset
//   in_val   per-channel valid
//   in_rdy   per-channel ready; at most one bit is set
//   in_msg   flattened input messages; channel i is [i*p_nbits +: p_nbits]
//   out_val  output valid
//   out_rdy  downstream ready
//   out_msg  registered output message
//   out_sel  source channel of out_msg
// ============================================================================
module vc_rr_stream_mux #(
    parameter int p_nbits   = 32,
    parameter int p_ninputs = 4,
    localparam int c_sel_nbits = (p_ninputs > 1) ? $clog2(p_ninputs) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_ninputs-1:0]           in_val,
    output logic [p_ninputs-1:0]           in_rdy,
    input  logic [p_ninputs*p_nbits-1:0]   in_msg,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_nbits-1:0]             out_msg,
    output logic [c_sel_nbits-1:0]         out_sel
);

    // One extra bit so that ptr + offset never overflows before the wrap.
    localparam int c_sum_nbits = c_sel_nbits + 1;
    localparam logic [c_sel_nbits-1:0] c_last_idx = c_sel_nbits'(p_ninputs - 1);

    // ------------------------------------------------------------------------
    // Unflatten the input message bus
    // ------------------------------------------------------------------------
    logic [p_nbits-1:0] in_msg_arr [p_ninputs];

    for (genvar gi = 0; gi < p_ninputs; gi++) begin : g_unpack
        assign in_msg_arr[gi] = in_msg[gi*p_nbits +: p_nbits];
    end

    // ------------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------------
    logic [c_sel_nbits-1:0] ptr_q;
    logic [c_sel_nbits-1:0] ptr_d;
    logic [c_sel_nbits-1:0] grant_idx;
    logic [c_sel_nbits-1:0] grant_next_ptr;
    logic                   grant_any;
    logic                   enq_ok;
    logic                   in_xfer;

    // (base + off) mod p_ninputs, where base and off are both < p_ninputs.
    function automatic logic [c_sel_nbits-1:0] wrap_add(
        input logic [c_sel_nbits-1:0] base,
        input int                     off
    );
        logic [c_sum_nbits-1:0] sum;
        sum = {1'b0, base} + c_sum_nbits'(off);
        if (sum >= c_sum_nbits'(p_ninputs)) begin
            sum = sum - c_sum_nbits'(p_ninputs);
        end
        return sum[c_sel_nbits-1:0];
    endfunction

    // The loop scans offsets from the far end down to 0. The last hit
    // therefore wins, which is the valid channel closest to ptr_q.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = p_ninputs - 1; k >= 0; k--) begin
            if (in_val[wrap_add(ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_add(ptr_q, k);
            end
        end
    end

    assign grant_next_ptr = (grant_idx == c_last_idx) ? '0
                                                      : grant_idx + c_sel_nbits'(1);

    assign in_xfer = grant_any && enq_ok && !reset;

    for (genvar gi = 0; gi < p_ninputs; gi++) begin : g_rdy
        assign in_rdy[gi] = in_xfer && (grant_idx == c_sel_nbits'(gi));
    end

    // The pointer only advances when an input transfer is accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (in_xfer) begin
            ptr_d = grant_next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef VC_RR_STREAM_MUX_SKID_EN
    // ------------------------------------------------------------------------
    // Output stage: 2-entry FIFO (skid buffer)
    // ------------------------------------------------------------------------
    logic [p_nbits-1:0]     stor_msg_q [2];
    logic [c_sel_nbits-1:0] stor_sel_q [2];
    logic [1:0]             count_q;
    logic [1:0]             count_d;
    logic                   head_q;
    logic                   head_d;
    logic                   wr_idx;
    logic                   deq;

    // in_rdy depends only on the registered occupancy, not on out_rdy.
    assign enq_ok = (count_q != 2'd2);
    assign deq    = (count_q != 2'd0) && out_rdy;
    // Enqueue is only possible with count 0 or 1, so the tail is head + count.
    assign wr_idx = head_q ^ count_q[0];

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (in_xfer && !deq) begin
            count_d = count_q + 2'd1;
        end else if (!in_xfer && deq) begin
            count_d = count_q - 2'd1;
        end
        if (deq) begin
            head_d = ~head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                stor_msg_q[e] <= '0;
                stor_sel_q[e] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (in_xfer) begin
                stor_msg_q[wr_idx] <= in_msg_arr[grant_idx];
                stor_sel_q[wr_idx] <= grant_idx;
            end
        end
    end

    assign out_val = (count_q != 2'd0);
    assign out_msg = stor_msg_q[head_q];
    assign out_sel = stor_sel_q[head_q];
`else
    // ------------------------------------------------------------------------
    // Output stage: 1-entry pipe register
    // ------------------------------------------------------------------------
    logic                   full_q;
    logic                   full_d;
    logic [p_nbits-1:0]     msg_q;
    logic [p_nbits-1:0]     msg_d;
    logic [c_sel_nbits-1:0] sel_q;
    logic [c_sel_nbits-1:0] sel_d;

    // A full register can still accept a new message if it is drained in
    // the same cycle. This gives 1 msg/cycle, at the cost of a combinational
    // path from out_rdy to in_rdy.
    assign enq_ok = !full_q || out_rdy;

    always_comb begin
        full_d = full_q;
        msg_d  = msg_q;
        sel_d  = sel_q;
        if (in_xfer) begin
            full_d = 1'b1;
            msg_d  = in_msg_arr[grant_idx];
            sel_d  = grant_idx;
        end else if (out_rdy) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            msg_q  <= '0;
            sel_q  <= '0;
        end else begin
            full_q <= full_d;
            msg_q  <= msg_d;
            sel_q  <= sel_d;
        end
    end

    assign out_val = full_q;
    assign out_msg = msg_q;
    assign out_sel = sel_q;
`endif

endmodule

// File: tb/tb_vc_rr_stream_mux.sv
module tb_vc_rr_stream_mux;

    logic         clk = 1'b0;
    logic         reset;

    // Instance A: 4 channels of 32 bits
    logic [3:0]   in_val;
    logic [3:0]   in_rdy;
    logic [127:0] in_msg;
    logic         out_val;
    logic         out_rdy;
    logic [31:0]  out_msg;
    logic [1:0]   out_sel;

    // Instance B: 3 channels of 32 bits (non-power-of-two)
    logic [2:0]   in_val_b;
    logic [2:0]   in_rdy_b;
    logic [95:0]  in_msg_b;
    logic         out_val_b;
    logic         out_rdy_b;
    logic [31:0]  out_msg_b;
    logic [1:0]   out_sel_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vc_rr_stream_mux #(.p_nbits(32), .p_ninputs(4)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_sel (out_sel)
    );

    vc_rr_stream_mux #(.p_nbits(32), .p_ninputs(3)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val_b),
        .in_rdy  (in_rdy_b),
        .in_msg  (in_msg_b),
        .out_val (out_val_b),
        .out_rdy (out_rdy_b),
        .out_msg (out_msg_b),
        .out_sel (out_sel_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; inputs are driven and outputs sampled
    // well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_val    = 4'b1111;
        out_rdy   = 1'b1;
        in_val_b  = 3'b000;
        out_rdy_b = 1'b1;
        for (int i = 0; i < 4; i++) in_msg[i*32 +: 32] = 32'hA0 + 32'(i);
        for (int i = 0; i < 3; i++) in_msg_b[i*32 +: 32] = 32'hB0 + 32'(i);

        // ---------------- reset hold ----------------
        repeat (3) tick();
        #1;
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_in_rdy",  64'(in_rdy),  64'b0000);
        check("rst_out_msg", 64'(out_msg), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_grant", 64'(in_rdy), 64'b0001);

        // ---------------- round-robin sweep ----------------
        for (int k = 0; k < 5; k++) begin
            check($sformatf("sweep%0d_in_rdy", k), 64'(in_rdy), 64'(4'b0001 << (k % 4)));
            tick();
            #1;
            check($sformatf("sweep%0d_out_val", k), 64'(out_val), 64'd1);
            check($sformatf("sweep%0d_out_msg", k), 64'(out_msg), 64'(32'hA0 + 32'(k % 4)));
            check($sformatf("sweep%0d_out_sel", k), 64'(out_sel), 64'(k % 4));
        end

        // ---------------- sparse request wrap ----------------
        // ptr is 1 here; granting channel 2 moves it to 3.
        in_val = 4'b0100;
        tick();
        check("sparse_setup_sel", 64'(out_sel), 64'd2);
        in_val = 4'b0101;
        #1;
        check("sparse_rdy_wrap", 64'(in_rdy), 64'b0001);
        tick();
        #1;
        check("sparse_sel0", 64'(out_sel), 64'd0);
        check("sparse_rdy_next", 64'(in_rdy), 64'b0100);
        tick();
        check("sparse_sel2", 64'(out_sel), 64'd2);

`ifndef VC_RR_STREAM_MUX_SKID_EN
        // ---------------- backpressure (pipe build) ----------------
        // ptr is 3; only channel 1 is valid, so it wins and ptr becomes 2.
        in_msg[32 +: 32] = 32'h55;
        in_val = 4'b0010;
        #1;
        check("bp_fill_rdy", 64'(in_rdy), 64'b0010);
        tick();
        out_rdy = 1'b0;
        in_val  = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("bp%0d_out_msg", c), 64'(out_msg), 64'h55);
            check($sformatf("bp%0d_out_sel", c), 64'(out_sel), 64'd1);
            check($sformatf("bp%0d_out_val", c), 64'(out_val), 64'd1);
            check($sformatf("bp%0d_in_rdy", c),  64'(in_rdy),  64'b0000);
            tick();
        end
        out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 64'(in_rdy), 64'b0100);
        tick();
        #1;
        check("bp_after_msg", 64'(out_msg), 64'hA2);
        check("bp_after_sel", 64'(out_sel), 64'd2);
        in_val = 4'b0000;
        #1;
        check("idle_in_rdy", 64'(in_rdy), 64'b0000);
        tick();
        #1;
        check("drain_out_val", 64'(out_val), 64'd0);
`endif

        // ---------------- non-power-of-two, N=3 ----------------
        in_val_b = 3'b111;
        for (int k = 0; k < 7; k++) begin
            tick();
            #1;
            check($sformatf("n3_%0d_out_sel", k), 64'(out_sel_b), 64'(k % 3));
            check($sformatf("n3_%0d_out_msg", k), 64'(out_msg_b), 64'(32'hB0 + 32'(k % 3)));
        end
        in_val_b = 3'b000;

`ifdef VC_RR_STREAM_MUX_SKID_EN
        // ---------------- skid buffer ----------------
        in_val = 4'b0000;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        in_msg[0  +: 32] = 32'hC0;
        in_msg[32 +: 32] = 32'hC1;
        out_rdy = 1'b0;
        in_val  = 4'b0011;
        #1;
        check("skid_rdy0", 64'(in_rdy), 64'b0001);
        tick();
        #1;
        check("skid_head_msg", 64'(out_msg), 64'hC0);
        check("skid_rdy1", 64'(in_rdy), 64'b0010);
        tick();
        #1;
        check("skid_full_rdy", 64'(in_rdy), 64'b0000);
        tick();
        #1;
        check("skid_full_rdy2", 64'(in_rdy), 64'b0000);
        check("skid_full_msg", 64'(out_msg), 64'hC0);
        out_rdy = 1'b1;
        #1;
        check("skid_no_comb_rdy", 64'(in_rdy), 64'b0000);
        tick();
        #1;
        check("skid_second_msg", 64'(out_msg), 64'hC1);
        check("skid_second_sel", 64'(out_sel), 64'd1);
        check("skid_rdy_back", 64'(in_rdy), 64'b0001);
        in_val = 4'b0000;
        tick();
        #1;
        check("skid_empty", 64'(out_val), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vc_rr_stream_mux.md
Name: vc_rr_stream_mux

Overview:
Parametrised N-input stream multiplexer with val/rdy handshakes on every input channel and on the single output.
- Selection is not driven externally: a round-robin arbiter picks among the valid inputs.
- The winning message is registered, giving a 1-cycle latency and tagging each message with its source channel.
- Used wherever several producers share one downstream consumer (memory ports, network injection, shared functional units).

Parameters:
p_nbits, 32, message width in bits
p_ninputs, 4, number of input channels (>=1; need not be a power of two)
c_sel_nbits, derived localparam = max(1, $clog2(p_ninputs)), width of channel-id fields

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_val  input  p_ninputs  per-channel valid; bit i belongs to channel i
in_rdy  output  p_ninputs  per-channel ready; at most one bit set per cycle
in_msg  input  p_ninputs*p_nbits  flattened messages; channel i occupies bits [i*p_nbits +: p_nbits]
out_val  output  1  output message valid
out_rdy  input  1  downstream ready
out_msg  output  p_nbits  registered message
out_sel  output  c_sel_nbits  channel id the current out_msg came from

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset, as decided.
- Reset state: out_val=0, out_msg=0, out_sel=0, round-robin pointer ptr=0 (channel 0 highest priority).
- Reset mid-operation discards any buffered message. in_rdy=0 during reset.
- Transfer rule: a transfer occurs on channel i when in_val[i] && in_rdy[i]. An output transfer occurs when out_val && out_rdy.
- Base mode, 1-entry pipe register:
  - enq_ok = !full || out_rdy.
  - This path from out_rdy to in_rdy is combinational.
- Arbitration (combinational):
  - grant = first set bit of in_val, searching from channel ptr upward and wrapping p_ninputs-1 -> 0.
  - in_rdy = grant one-hot AND enq_ok. in_rdy is all-zero if no in_val bit is set.
  - in_rdy[i] may depend on in_val; in_val must not depend on in_rdy.
- On input transfer from channel g:
  - out_msg <= in_msg[g], out_sel <= g, full <= 1.
  - ptr <= (g+1) wraps to 0 when g = p_ninputs-1.
- ptr changes only on an accepted input transfer. Stalls and idle cycles leave it unchanged.
- Dequeue with no new input: full && out_rdy with no input transfer -> full <= 0.
- Simultaneous dequeue and enqueue: the register is overwritten with the new message; out_val stays 1, giving full throughput of 1 msg/cycle.
- Output stability: while out_val && !out_rdy, out_msg and out_sel must not change and all in_rdy are 0.
- Latency: a message accepted in cycle t appears on out_msg in cycle t+1.
- Fairness: with all channels continuously valid and out_rdy=1, grants cycle 0,1,..,N-1,0,...; no channel waits more than N-1 transfers.
- p_ninputs=1: degenerates to a pipe register. out_sel is constantly 0 and ptr stays 0.
- A source withdrawing in_val before being granted is tolerated; arbitration re-evaluates every cycle.
- No X may propagate to out_val or in_rdy after reset.

Optional Feature:
Macro VC_RR_STREAM_MUX_SKID_EN.
- Defined:
  - The output stage becomes a 2-entry FIFO (skid buffer).
  - enq_ok = (count < 2), a function of registered state only. This removes the combinational out_rdy -> in_rdy path.
  - Enqueue and dequeue may both occur in the same cycle.
  - out_msg and out_sel come from the head entry. Messages are delivered in acceptance order.
  - Latency remains 1 cycle. Sustained throughput is 1 msg/cycle.
  - Reset empties both entries.
- Not defined: the base 1-entry pipe behaviour above applies.
- Ports, parameters, arbitration order and pointer-update rules are identical in both builds.

Test Plan:
- Reset hold: assert reset 3 cycles with all in_val=1 -> out_val=0, in_rdy=0000, out_msg=0, out_sel=0. The first post-reset grant goes to channel 0.
- Round-robin sweep: N=4, nbits=32, in_val=1111 with in_msg[i]=0xA0+i, out_rdy=1 -> out_msg sequence A0,A1,A2,A3,A0 on consecutive cycles starting 1 cycle after first grant, with out_sel 0,1,2,3,0.
- Sparse request wrap: ptr=3, in_val=0101 -> channel 0 granted, then ptr=1. Next cycle, same in_val -> channel 2 granted.
- Backpressure: fill the output with msg 0x55 from ch1, hold out_rdy=0 for 4 cycles with in_val=1111 -> out_msg=0x55 and out_sel=1 stable, in_rdy=0000 (base), ptr unchanged. Release -> 0x55 dequeued and ch2 granted the same cycle.
- Non-power-of-two: N=3, in_val=111, out_rdy=1, 7 transfers -> out_sel 0,1,2,0,1,2,0. out_sel never equals 3.
- Skid build (VC_RR_STREAM_MUX_SKID_EN): out_rdy=0, in_val=0011 -> exactly 2 messages accepted (ch0 then ch1) and in_rdy=00 thereafter. out_rdy=1 -> ch0 msg then ch1 msg delivered, with in_rdy reasserted the cycle after count<2.
